incr_checker: RTL and testbench
===============================

Name: incr_checker

Overview:
- Downstream self-checking stage for the increment top-level: consumes the top's stimulus inputs (in_small/in_quad/in_wide), its reset_l, and its three outputs.
- Recomputes the expected response, compares all three lanes every sampled cycle, and accumulates mismatch statistics over a programmable sample window.
- Two-stage registered pipeline plus a run-control FSM; results are read by the C++ harness at end of test.

Parameters:
- W_SMALL, 2, width of small lane
- W_QUAD, 40, width of quad lane
- W_WIDE, 70, width of wide lane
- CNT_W, 16, width of sample/error counters

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse: begin a check window
- num_samples  input  CNT_W  number of cycles to check; sampled on accepted start
- dut_reset_l  input  1  reset_l as driven into the checked block (0 = block in reset)
- in_small  input  W_SMALL  stimulus driven to the checked block
- in_quad  input  W_QUAD  stimulus
- in_wide  input  W_WIDE  stimulus
- out_small  input  W_SMALL  checked block response
- out_quad  input  W_QUAD  response
- out_wide  input  W_WIDE  response
- busy  output  1  high in RUN or DRAIN
- done  output  1  high in DONE, held until next accepted start
- pass  output  1  done && err_count==0
- err_count  output  CNT_W  mismatching samples (saturating)
- err_lanes  output  3  sticky per-lane mismatch mask {wide,quad,small}
- first_err_idx  output  CNT_W  sample index (0-based) of first mismatch

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; busy=0, done=0, pass=0, err_count=0, err_lanes=0, first_err_idx=0; pipeline valid bits cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch num_samples; clear err_count, err_lanes, first_err_idx, sample_idx. If num_samples==0, go to DONE (pass=1). Otherwise go to RUN.
- start while in RUN or DRAIN: ignored.
- RUN: each cycle captures one vector into stage 1 with valid=1 and tag=sample_idx, then sample_idx++. Once num_samples vectors are captured, go to DRAIN.
- DRAIN: stays until both pipeline valid bits are 0 (2 cycles), then goes to DONE.
- Total latency from the last captured vector to done=1 is 2 cycles.
- Stage 1 registers all inputs.
- Stage 2 computes the expected value per lane:
  - if dut_reset_l==0: 0.
  - else: (in + 1) mod 2^W.
  - All-ones input wraps to 0; no carry between lanes.
- Stage 2 compare: a lane mismatches if expected != out. A sample mismatches if any lane mismatches.
- On a mismatched sample:
  - err_count++, saturating at 2^CNT_W-1.
  - err_lanes |= lane mask.
  - If this is the first error of the window, first_err_idx=tag.
- Mid-window reset: all state returns to reset values; in-flight samples are discarded.
- Outputs are registered; err_count and err_lanes update 2 cycles after the vector is present on the inputs.

Test Plan:
- start, num_samples=4, dut_reset_l=1, vectors in_small=0..3 with out_small=in+1 mod 4, quad/wide=in+1 -> busy for 6 cycles, done=1, pass=1, err_count=0, err_lanes=0.
- Wrap: in_small=2'b11, in_quad=40'hFF_FFFF_FFFF, in_wide=all ones, all outs=0, num_samples=1 -> pass=1.
- dut_reset_l=0, outs=0 with in_quad=5, num_samples=3 -> pass=1. Same window with out_quad=6 -> err_count=3, err_lanes=3'b010, first_err_idx=0.
- num_samples=10, out_wide corrupted only at sample 7 and out_small at sample 9 -> err_count=2, err_lanes=3'b101, first_err_idx=7, pass=0.
- num_samples=0 start -> done=1, pass=1 next cycle. A start pulse during RUN of an 8-sample window does not change the window length. A second start in DONE clears stats.
- reset asserted mid-RUN after 3 of 8 samples with 1 error seen -> all outputs 0 immediately; new start with clean data -> pass=1, err_count=0.

Source files
------------

// File: rtl/incr_checker_if.sv
// rtl/incr_checker_if.sv - stimulus/response bundle of the increment block as seen by the checker
interface incr_checker_if #(
    parameter int W_SMALL = 2,
    parameter int W_QUAD  = 40,
    parameter int W_WIDE  = 70
);
    logic               dut_reset_l;
    logic [W_SMALL-1:0] in_small;
    logic [W_QUAD-1:0]  in_quad;
    logic [W_WIDE-1:0]  in_wide;
    logic [W_SMALL-1:0] out_small;
    logic [W_QUAD-1:0]  out_quad;
    logic [W_WIDE-1:0]  out_wide;

    // Driver side: whoever produces the stimulus and the observed response.
    modport master (
        output dut_reset_l, in_small, in_quad, in_wide,
        output out_small, out_quad, out_wide
    );

    // Checker side: observes everything.
    modport slave (
        input dut_reset_l, in_small, in_quad, in_wide,
        input out_small, out_quad, out_wide
    );
endinterface

// File: rtl/incr_checker.sv
// rtl/incr_checker.sv - two-stage self-checker for the increment block with windowed error statistics
module incr_checker #(
    parameter int W_SMALL = 2,
    parameter int W_QUAD  = 40,
    parameter int W_WIDE  = 70,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    incr_checker_if.slave    i_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       err_lanes,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Window control
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_idx;
    logic             w_accept;
    logic             w_capture;

    // Stage 1: raw registered copy of everything on the bus
    logic               r_s1_valid;
    logic [CNT_W-1:0]   r_s1_tag;
    logic               r_s1_rst_l;
    logic [W_SMALL-1:0] r_s1_in_small;
    logic [W_QUAD-1:0]  r_s1_in_quad;
    logic [W_WIDE-1:0]  r_s1_in_wide;
    logic [W_SMALL-1:0] r_s1_out_small;
    logic [W_QUAD-1:0]  r_s1_out_quad;
    logic [W_WIDE-1:0]  r_s1_out_wide;

    // Stage 2: compare and accumulate
    logic               r_s2_valid;
    logic [W_SMALL-1:0] w_exp_small;
    logic [W_QUAD-1:0]  w_exp_quad;
    logic [W_WIDE-1:0]  w_exp_wide;
    logic [2:0]         w_lane_mis;
    logic [CNT_W-1:0]   r_err_count;
    logic [2:0]         r_err_lanes;
    logic [CNT_W-1:0]   r_first_err_idx;

    // Registered status
    logic r_busy;
    logic r_done;
    logic r_pass;

    // Next-state and per-cycle control strobes for the run-control FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (num_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_capture = 1'b1;
                if (r_idx == r_num - CNT_W'(1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last sample sits in stage 2 with nothing behind it: both
                // valid bits are clear once this edge retires it.
                if (!r_s1_valid && r_s2_valid) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Window length latch and running sample index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_num <= num_samples;
            r_idx <= '0;
        end else if (w_capture) begin
            r_idx <= r_idx + CNT_W'(1);
        end
    end

    // Stage 1: capture one tagged vector per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid     <= 1'b0;
            r_s1_tag       <= '0;
            r_s1_rst_l     <= 1'b0;
            r_s1_in_small  <= '0;
            r_s1_in_quad   <= '0;
            r_s1_in_wide   <= '0;
            r_s1_out_small <= '0;
            r_s1_out_quad  <= '0;
            r_s1_out_wide  <= '0;
        end else begin
            r_s1_valid <= w_capture;
            if (w_capture) begin
                r_s1_tag       <= r_idx;
                r_s1_rst_l     <= i_dut.dut_reset_l;
                r_s1_in_small  <= i_dut.in_small;
                r_s1_in_quad   <= i_dut.in_quad;
                r_s1_in_wide   <= i_dut.in_wide;
                r_s1_out_small <= i_dut.out_small;
                r_s1_out_quad  <= i_dut.out_quad;
                r_s1_out_wide  <= i_dut.out_wide;
            end
        end
    end

    // Expected response per lane; each lane wraps independently and a held
    // block reset forces every output to zero.
    always_comb begin
        w_exp_small = '0;
        w_exp_quad  = '0;
        w_exp_wide  = '0;
        if (r_s1_rst_l) begin
            w_exp_small = r_s1_in_small + W_SMALL'(1);
            w_exp_quad  = r_s1_in_quad + W_QUAD'(1);
            w_exp_wide  = r_s1_in_wide + W_WIDE'(1);
        end
        w_lane_mis = {(w_exp_wide  != r_s1_out_wide),
                      (w_exp_quad  != r_s1_out_quad),
                      (w_exp_small != r_s1_out_small)};
    end

    // Stage 2: accumulate mismatch statistics; a zero error count marks the
    // first error of the window since the counter saturates rather than wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid      <= 1'b0;
            r_err_count     <= '0;
            r_err_lanes     <= '0;
            r_first_err_idx <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (w_accept) begin
                r_err_count     <= '0;
                r_err_lanes     <= '0;
                r_first_err_idx <= '0;
            end else if (r_s1_valid && (w_lane_mis != 3'b000)) begin
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
                r_err_lanes <= r_err_lanes | w_lane_mis;
                if (r_err_count == '0) begin
                    r_first_err_idx <= r_s1_tag;
                end
            end
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done <= (w_state_nxt == S_DONE);
            // Stats never change on the edge that enters or holds DONE,
            // except when a start clears them.
            r_pass <= (w_state_nxt == S_DONE) && (w_accept || (r_err_count == '0));
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign err_lanes     = r_err_lanes;
    assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_incr_checker.sv
// tb/tb_incr_checker.sv - directed self-checking bench for incr_checker
module tb_incr_checker;

    localparam int W_SMALL = 2;
    localparam int W_QUAD  = 40;
    localparam int W_WIDE  = 70;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [2:0]       err_lanes;
    logic [CNT_W-1:0] first_err_idx;

    int checks;
    int failures;

    incr_checker_if #(.W_SMALL(W_SMALL), .W_QUAD(W_QUAD), .W_WIDE(W_WIDE)) dif ();

    incr_checker #(
        .W_SMALL(W_SMALL), .W_QUAD(W_QUAD), .W_WIDE(W_WIDE), .CNT_W(CNT_W)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_samples  (num_samples),
        .i_dut        (dif),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .err_lanes    (err_lanes),
        .first_err_idx(first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector tables
    logic               v_rstl  [16];
    logic [W_SMALL-1:0] v_small [16];
    logic [W_QUAD-1:0]  v_quad  [16];
    logic [W_WIDE-1:0]  v_wide  [16];
    logic [W_SMALL-1:0] o_small [16];
    logic [W_QUAD-1:0]  o_quad  [16];
    logic [W_WIDE-1:0]  o_wide  [16];

    task automatic fill_clean(input int n, input logic [W_WIDE-1:0] base);
        for (int k = 0; k < n; k++) begin
            v_rstl[k]  = 1'b1;
            v_small[k] = 2'(k);
            v_quad[k]  = base[W_QUAD-1:0] + 40'(k);
            v_wide[k]  = base + 70'(k);
            o_small[k] = v_small[k] + 2'd1;
            o_quad[k]  = v_quad[k] + 40'd1;
            o_wide[k]  = v_wide[k] + 70'd1;
        end
    endtask

    task automatic apply_vec(input int c);
        dif.dut_reset_l = v_rstl[c];
        dif.in_small    = v_small[c];
        dif.in_quad     = v_quad[c];
        dif.in_wide     = v_wide[c];
        dif.out_small   = o_small[c];
        dif.out_quad    = o_quad[c];
        dif.out_wide    = o_wide[c];
    endtask

    // Start a window of n samples, stream vectors, wait (bounded) for done.
    // A second start pulse is raised at iteration restart_at (if >= 0).
    task automatic drive_window(input int n, input int restart_at, output int busy_cyc, output bit timed_out);
        @(negedge clk);
        start       = 1'b1;
        num_samples = 16'(n);
        @(negedge clk);
        start     = 1'b0;
        busy_cyc  = 0;
        timed_out = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cyc++;
            start = (c == restart_at);
            if (start) num_samples = 16'd3;
            if (c < n) apply_vec(c);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%0b exp=0", pass); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        checks++; if (err_lanes !== 3'b000) begin failures++; $display("FAIL reset_err_lanes got=%b exp=000", err_lanes); end
        checks++; if (first_err_idx !== 16'd0) begin failures++; $display("FAIL reset_first_idx got=%0d exp=0", first_err_idx); end
    endtask

    task automatic test_basic();
        int bc; bit to;
        fill_clean(4, 70'h2A_5555_0000_FFFF_FFFE);
        drive_window(4, -1, bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%0b exp=0", to); end
        checks++; if (bc !== 6) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=6", bc); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL basic_pass got=%0b exp=1", pass); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL basic_err_count got=%0d exp=0", err_count); end
        checks++; if (err_lanes !== 3'b000) begin failures++; $display("FAIL basic_err_lanes got=%b exp=000", err_lanes); end
    endtask

    task automatic test_wrap();
        int bc; bit to;
        v_rstl[0]  = 1'b1;
        v_small[0] = 2'b11;
        v_quad[0]  = 40'hFF_FFFF_FFFF;
        v_wide[0]  = 70'h3F_FFFF_FFFF_FFFF_FFFF;
        o_small[0] = 2'b00;
        o_quad[0]  = 40'h0;
        o_wide[0]  = 70'h0;
        drive_window(1, -1, bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL wrap_timeout got=%0b exp=0", to); end
        checks++; if (bc !== 3) begin failures++; $display("FAIL wrap_busy_cycles got=%0d exp=3", bc); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL wrap_pass got=%0b exp=1", pass); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL wrap_err_count got=%0d exp=0", err_count); end
    endtask

    task automatic test_dut_in_reset();
        int bc; bit to;
        for (int k = 0; k < 3; k++) begin
            v_rstl[k]  = 1'b0;
            v_small[k] = 2'(k + 1);
            v_quad[k]  = 40'd5;
            v_wide[k]  = 70'(k + 7);
            o_small[k] = 2'd0;
            o_quad[k]  = 40'd0;
            o_wide[k]  = 70'd0;
        end
        drive_window(3, -1, bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL rstl_timeout got=%0b exp=0", to); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL rstl_pass got=%0b exp=1", pass); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL rstl_err_count got=%0d exp=0", err_count); end
        for (int k = 0; k < 3; k++) o_quad[k] = 40'd6;
        drive_window(3, -1, bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL rstl_bad_timeout got=%0b exp=0", to); end
        checks++; if (err_count !== 16'd3) begin failures++; $display("FAIL rstl_bad_err_count got=%0d exp=3", err_count); end
        checks++; if (err_lanes !== 3'b010) begin failures++; $display("FAIL rstl_bad_err_lanes got=%b exp=010", err_lanes); end
        checks++; if (first_err_idx !== 16'd0) begin failures++; $display("FAIL rstl_bad_first_idx got=%0d exp=0", first_err_idx); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL rstl_bad_pass got=%0b exp=0", pass); end
    endtask

    task automatic test_multi_err();
        int bc; bit to;
        fill_clean(10, 70'h01_2345_6789_ABCD_EF00);
        o_wide[7]  = o_wide[7] ^ 70'h20_0000_0000_0000_0000;
        o_small[9] = o_small[9] ^ 2'b01;
        drive_window(10, -1, bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL multi_timeout got=%0b exp=0", to); end
        checks++; if (bc !== 12) begin failures++; $display("FAIL multi_busy_cycles got=%0d exp=12", bc); end
        checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL multi_err_count got=%0d exp=2", err_count); end
        checks++; if (err_lanes !== 3'b101) begin failures++; $display("FAIL multi_err_lanes got=%b exp=101", err_lanes); end
        checks++; if (first_err_idx !== 16'd7) begin failures++; $display("FAIL multi_first_idx got=%0d exp=7", first_err_idx); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL multi_pass got=%0b exp=0", pass); end
    endtask

    // Runs straight after test_multi_err so the restart from DONE must clear stats.
    task automatic test_zero_len();
        int bc; bit to;
        drive_window(0, -1, bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL zero_timeout got=%0b exp=0", to); end
        checks++; if (bc !== 0) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=0", bc); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL zero_pass got=%0b exp=1", pass); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL zero_err_count got=%0d exp=0", err_count); end
        checks++; if (err_lanes !== 3'b000) begin failures++; $display("FAIL zero_err_lanes got=%b exp=000", err_lanes); end
        checks++; if (first_err_idx !== 16'd0) begin failures++; $display("FAIL zero_first_idx got=%0d exp=0", first_err_idx); end
    endtask

    task automatic test_start_in_run();
        int bc; bit to;
        fill_clean(8, 70'h00_0000_0000_0000_0100);
        o_quad[6] = o_quad[6] ^ 40'h80_0000_0000;
        drive_window(8, 2, bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL restart_timeout got=%0b exp=0", to); end
        checks++; if (bc !== 10) begin failures++; $display("FAIL restart_busy_cycles got=%0d exp=10", bc); end
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL restart_err_count got=%0d exp=1", err_count); end
        checks++; if (err_lanes !== 3'b010) begin failures++; $display("FAIL restart_err_lanes got=%b exp=010", err_lanes); end
        checks++; if (first_err_idx !== 16'd6) begin failures++; $display("FAIL restart_first_idx got=%0d exp=6", first_err_idx); end
    endtask

    task automatic test_reset_mid_run();
        int bc; bit to;
        fill_clean(8, 70'h15_0000_0000_0000_0000);
        o_quad[1] = o_quad[1] ^ 40'h1;
        @(negedge clk);
        start       = 1'b1;
        num_samples = 16'd8;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply_vec(c);
            @(negedge clk);
        end
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL midrst_pre_err_count got=%0d exp=1", err_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy got=%0b exp=1", busy); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b exp=0", done); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL midrst_err_count got=%0d exp=0", err_count); end
        checks++; if (err_lanes !== 3'b000) begin failures++; $display("FAIL midrst_err_lanes got=%b exp=000", err_lanes); end
        checks++; if (first_err_idx !== 16'd0) begin failures++; $display("FAIL midrst_first_idx got=%0d exp=0", first_err_idx); end
        @(negedge clk);
        reset = 1'b0;
        fill_clean(8, 70'h15_0000_0000_0000_0000);
        drive_window(8, -1, bc, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL midrst_after_timeout got=%0b exp=0", to); end
        checks++; if (bc !== 10) begin failures++; $display("FAIL midrst_after_busy_cycles got=%0d exp=10", bc); end
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL midrst_after_pass got=%0b exp=1", pass); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL midrst_after_err_count got=%0d exp=0", err_count); end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        start           = 1'b0;
        num_samples     = '0;
        dif.dut_reset_l = 1'b0;
        dif.in_small    = '0;
        dif.in_quad     = '0;
        dif.in_wide     = '0;
        dif.out_small   = '0;
        dif.out_quad    = '0;
        dif.out_wide    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_dut_in_reset();
        test_multi_err();
        test_zero_len();
        test_start_in_run();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
